pci_mem_target: RTL and testbench
=================================

Name: pci_mem_target

Overview:
PCI target (slave) that claims memory read and memory write transactions to a fixed address window and services them from an internal word-addressed memory. It samples FRAME_, IRDY_, C_BE_ and AD from the master. It drives DEVSEL_, TRDY_ and read data. It is the responder whose bus behaviour the team's PCI protocol property checker monitors.

Parameters:
BASE_ADDR, 32'h1000_0000, window base; hit when AD[31:ADDR_BITS+2] equals BASE_ADDR[31:ADDR_BITS+2].
ADDR_BITS, 4, log2 of memory depth in 32-bit words (16 words).
DEVSEL_DLY, 1, edges from address phase to DEVSEL_ low; legal values 1 (fast), 2 (medium), 3 (slow).
WAIT_STATES, 0, extra edges before the first TRDY_ of a transaction; legal range 0..3.

Ports:
clk  in  1  bus clock; all sampling on posedge.
reset  in  1  asynchronous, active-high reset.
FRAME_  in  1  active-low; master cycle framing.
IRDY_  in  1  active-low; master ready.
C_BE_  in  4  command during address phase; active-low byte enables during data phases.
ad_in  in  32  AD as sampled from the bus.
ad_out  out  32  read data driven toward AD.
ad_oe  out  1  high when the target drives AD.
DEVSEL_  out  1  active-low device select.
TRDY_  out  1  active-low target ready.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous, active-high.
- Reset values: DEVSEL_=1, TRDY_=1, ad_oe=0, ad_out=0, state IDLE, all memory words=0, frame_q=1.
- Address phase: an edge where FRAME_=0 and frame_q=1 (registered FRAME_). Call it E0.
- Address phase is recognised only in IDLE. A FRAME_ fall in any other state is ignored.
- Commands: C_BE_=4'b0110 is a memory read; 4'b0111 is a memory write. Any other command, or an address miss, is not claimed: stay IDLE with no outputs changed.
- On a claim at E0: latch idx=ad_in[ADDR_BITS+1:2] and the read/write flag. ad_in[1:0] is ignored (linear burst assumed).
- States: IDLE -> DECODE -> WAIT -> DATA -> IDLE.
  - DECODE counts DEVSEL_DLY edges.
  - WAIT counts the remaining initial latency.
- DEVSEL_ goes low after edge E0+DEVSEL_DLY-1 (registered), so it is first sampled low at E0+DEVSEL_DLY.
- First TRDY_ is sampled low at E0+L:
  - write: L = DEVSEL_DLY+WAIT_STATES;
  - read: L = max(DEVSEL_DLY+WAIT_STATES, 2), which guarantees one turnaround cycle.
- Reads: ad_oe rises together with DEVSEL_. ad_out = mem[idx] combinationally while ad_oe=1, else 0.
- TRDY_ is never low while DEVSEL_ is high.
- Transfer: any edge in DATA with IRDY_=0 and TRDY_=0.
  - Write transfer: each byte lane b is written from ad_in[8b+7:8b] only if C_BE_[b]=0. C_BE_=4'hF is a valid no-op data phase.
  - Every transfer: idx <= idx+1, wrapping from 2^ADDR_BITS-1 to 0.
- After the first transfer, TRDY_ stays low; the burst is zero-wait from the target side. Master stalls (IRDY_=1) hold idx and data unchanged.
- Termination: a transfer at an edge where FRAME_=1 is the last. After that edge DEVSEL_=1, TRDY_=1, ad_oe=0, and state is IDLE.
  - A new address phase is accepted on the next edge where FRAME_ falls again (frame_q=1 required).
- Master abandons before first TRDY_ (FRAME_=1 and IRDY_=1 sampled in DECODE or WAIT): return to IDLE and deassert outputs on that edge.
- Reset asserted mid-burst: outputs go to reset values immediately (asynchronous). Memory is cleared and the transaction is dropped.

Decomposition:
- Shared package pci_pkg holds:
  - command localparams CMD_MEM_READ=4'b0110 and CMD_MEM_WRITE=4'b0111;
  - the target state enum (IDLE, DECODE, WAIT, DATA);
  - the 32-bit word typedef.
- One sub-module, pci_target_mem: 2^ADDR_BITS x 32 array with asynchronous clear, per-byte write enable and combinational read port.
- The FSM, counters and decode live in pci_mem_target.

Test Plan:
- Single write/read, defaults: write 32'hDEADBEEF to 32'h1000_0008 with BE_=0, then read 32'h1000_0008 -> DEVSEL_ low at E0+1. Write TRDY_ is sampled low at E0+1; read TRDY_ at E0+2. ad_out=32'hDEADBEEF with ad_oe=1.
- Burst with wrap: write 4 words 1,2,3,4 starting at word 14 -> mem[14]=1, mem[15]=2, mem[0]=3, mem[1]=4. A 4-word read from word 14 returns 1,2,3,4.
- Byte enables: mem[3]=32'h11223344, then write 32'hAABBCCDD with C_BE_=4'b1010 -> mem[3]=32'h11BB33DD.
- Miss and unsupported command: address 32'h2000_0000, or C_BE_=4'b0010 at 32'h1000_0000 -> DEVSEL_, TRDY_ and ad_oe stay inactive for the whole cycle. Memory is unchanged.
- Latency sweep: DEVSEL_DLY=3, WAIT_STATES=2 -> DEVSEL_ first low at E0+3 and TRDY_ first low at E0+5. Master IRDY_ stalls of 2 cycles mid-burst -> no idx advance during the stall.
- Reset mid-burst: assert reset between transfers 2 and 3 of a 4-word write -> DEVSEL_/TRDY_ go 1 and ad_oe goes 0 within the same cycle. After release, a read of word 0 returns 0.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI memory target: bus commands, the target
// sequencer states, the data word type and the byte-lane merge helper.
package pci_pkg;

    // Bus commands presented on C_BE_ during the address phase.
    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    // Target sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        WAIT   = 2'd2,
        DATA   = 2'd3
    } pci_state_e;

    // One 32-bit bus word.
    typedef logic [31:0] word_t;

    // Replace the byte lanes of old_w selected by be (active-high) with
    // the corresponding lanes of new_w.
    function automatic word_t byte_merge(input word_t old_w,
                                         input word_t new_w,
                                         input logic [3:0] be);
        word_t res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pci_mem_target_if.sv
// Bus-side signal bundle of the PCI memory target. The master modport is
// the view of the initiator (or a bench acting as one); the slave modport
// is the target's view.
interface pci_mem_target_if;
    import pci_pkg::*;

    logic       FRAME_;   // active-low cycle framing
    logic       IRDY_;    // active-low initiator ready
    logic [3:0] C_BE_;    // command / active-low byte enables
    word_t      ad_in;    // AD as sampled from the bus
    word_t      ad_out;   // read data toward AD
    logic       ad_oe;    // target drives AD
    logic       DEVSEL_;  // active-low device select
    logic       TRDY_;    // active-low target ready

    modport master (
        output FRAME_, IRDY_, C_BE_, ad_in,
        input  ad_out, ad_oe, DEVSEL_, TRDY_
    );

    modport slave (
        input  FRAME_, IRDY_, C_BE_, ad_in,
        output ad_out, ad_oe, DEVSEL_, TRDY_
    );

endinterface

// File: rtl/pci_target_mem.sv
// Word-addressed storage behind the PCI memory target: 2^ADDR_BITS words,
// asynchronous clear, byte-masked synchronous write, combinational read.
module pci_target_mem
    import pci_pkg::*;
#(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [3:0]           wr_be,     // active-high lane enables
    input  logic [ADDR_BITS-1:0] wr_idx,
    input  word_t                wr_data,
    input  logic [ADDR_BITS-1:0] rd_idx,
    output word_t                rd_data
);

    localparam int DEPTH = 1 << ADDR_BITS;

    word_t mem_r [DEPTH];

    // Storage array: cleared by reset, byte-lane merge on a write transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (wr_en) begin
            mem_r[wr_idx] <= byte_merge(mem_r[wr_idx], wr_data, wr_be);
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/pci_mem_target.sv
// PCI memory target. Claims memory read/write commands that hit a fixed
// address window, inserts the configured DEVSEL_ and initial TRDY_ latency,
// then streams a zero-wait linear burst out of / into pci_target_mem.
module pci_mem_target
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          ADDR_BITS   = 4,
    parameter int          DEVSEL_DLY  = 1,   // 1 fast, 2 medium, 3 slow
    parameter int          WAIT_STATES = 0    // 0..3
) (
    input  logic clk,
    input  logic reset,
    pci_mem_target_if.slave bus
);

    // Edge (counted from 1 at the address phase) whose registered result is
    // the first low DEVSEL_ / TRDY_. Reads never go below 2 so the bus gets
    // a turnaround cycle before read data is qualified.
    localparam int LAT_WR = DEVSEL_DLY + WAIT_STATES;
    localparam int LAT_RD = (LAT_WR < 2) ? 2 : LAT_WR;
    localparam int CNT_W  = 3;

    localparam logic [CNT_W-1:0] DEV_CNT     = CNT_W'(DEVSEL_DLY);
    localparam logic [CNT_W-1:0] TRDY_CNT_WR = CNT_W'(LAT_WR);
    localparam logic [CNT_W-1:0] TRDY_CNT_RD = CNT_W'(LAT_RD);

    // Registered state
    pci_state_e             state_r;
    logic [CNT_W-1:0]       cnt_r;       // edges counted since the address phase
    logic [ADDR_BITS-1:0]   idx_r;       // current burst word
    logic                   rd_r;        // 1 = memory read in progress
    logic                   frame_q_r;   // FRAME_ seen at the previous edge
    logic                   devsel_n_r;
    logic                   trdy_n_r;
    logic                   ad_oe_r;

    // Next-state values
    pci_state_e             state_nxt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [ADDR_BITS-1:0]   idx_nxt;
    logic                   rd_nxt;
    logic                   devsel_n_nxt;
    logic                   trdy_n_nxt;
    logic                   ad_oe_nxt;

    // Decode helpers
    logic                   hit_s;
    logic                   cmd_ok_s;
    logic                   step_s;      // advance the latency counter this edge
    logic                   step_rd_s;   // direction used for that step
    logic [CNT_W-1:0]       ecount_s;    // edge number of this edge (1 = address phase)
    logic                   dev_now_s;
    logic                   trdy_now_s;
    logic                   xfer_s;

    // Memory port
    logic                   wr_en_s;
    logic [3:0]             wr_be_s;
    word_t                  rd_word_s;

    assign hit_s    = (bus.ad_in[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    assign cmd_ok_s = (bus.C_BE_ == CMD_MEM_READ) || (bus.C_BE_ == CMD_MEM_WRITE);
    assign xfer_s   = (state_r == DATA) && !bus.IRDY_ && !trdy_n_r;
    assign wr_en_s  = xfer_s && !rd_r;
    assign wr_be_s  = ~bus.C_BE_;

    pci_target_mem #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_be   (wr_be_s),
        .wr_idx  (idx_r),
        .wr_data (bus.ad_in),
        .rd_idx  (idx_r),
        .rd_data (rd_word_s)
    );

    // Next-state and next-output decode of the target sequencer.
    always_comb begin
        state_nxt    = state_r;
        cnt_nxt      = cnt_r;
        idx_nxt      = idx_r;
        rd_nxt       = rd_r;
        devsel_n_nxt = devsel_n_r;
        trdy_n_nxt   = trdy_n_r;
        ad_oe_nxt    = ad_oe_r;
        step_s       = 1'b0;
        step_rd_s    = rd_r;
        ecount_s     = cnt_r + CNT_W'(1);
        dev_now_s    = 1'b0;
        trdy_now_s   = 1'b0;

        case (state_r)
            IDLE: begin
                // Address phase: FRAME_ just fell and the command/address are ours.
                if (!bus.FRAME_ && frame_q_r && hit_s && cmd_ok_s) begin
                    step_s    = 1'b1;
                    step_rd_s = (bus.C_BE_ == CMD_MEM_READ);
                    ecount_s  = CNT_W'(1);
                    rd_nxt    = (bus.C_BE_ == CMD_MEM_READ);
                    idx_nxt   = bus.ad_in[ADDR_BITS+1:2];
                end else begin
                    state_nxt = IDLE;
                end
            end
            DECODE, WAIT: begin
                // Master gave up before the first data phase completed.
                if (bus.FRAME_ && bus.IRDY_) begin
                    state_nxt    = IDLE;
                    cnt_nxt      = {CNT_W{1'b0}};
                    devsel_n_nxt = 1'b1;
                    trdy_n_nxt   = 1'b1;
                    ad_oe_nxt    = 1'b0;
                end else begin
                    step_s = 1'b1;
                end
            end
            DATA: begin
                if (xfer_s) begin
                    idx_nxt = idx_r + ADDR_BITS'(1);
                    // FRAME_ already high marks the final data phase.
                    if (bus.FRAME_) begin
                        state_nxt    = IDLE;
                        cnt_nxt      = {CNT_W{1'b0}};
                        devsel_n_nxt = 1'b1;
                        trdy_n_nxt   = 1'b1;
                        ad_oe_nxt    = 1'b0;
                    end else begin
                        state_nxt = DATA;
                    end
                end else begin
                    state_nxt = DATA;
                end
            end
            default: begin
                state_nxt    = IDLE;
                cnt_nxt      = {CNT_W{1'b0}};
                devsel_n_nxt = 1'b1;
                trdy_n_nxt   = 1'b1;
                ad_oe_nxt    = 1'b0;
            end
        endcase

        // Initial latency: DEVSEL_ (and read AD drive) then TRDY_ as the
        // edge count reaches each threshold.
        if (step_s) begin
            dev_now_s    = (ecount_s >= DEV_CNT);
            trdy_now_s   = (ecount_s >= (step_rd_s ? TRDY_CNT_RD : TRDY_CNT_WR));
            cnt_nxt      = ecount_s;
            devsel_n_nxt = !dev_now_s;
            ad_oe_nxt    = dev_now_s && step_rd_s;
            trdy_n_nxt   = !trdy_now_s;
            if (trdy_now_s) begin
                state_nxt = DATA;
            end else if (dev_now_s) begin
                state_nxt = WAIT;
            end else begin
                state_nxt = DECODE;
            end
        end else begin
            dev_now_s  = 1'b0;
            trdy_now_s = 1'b0;
        end
    end

    // Sequencer state, burst pointer and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            idx_r      <= {ADDR_BITS{1'b0}};
            rd_r       <= 1'b0;
            frame_q_r  <= 1'b1;
            devsel_n_r <= 1'b1;
            trdy_n_r   <= 1'b1;
            ad_oe_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            cnt_r      <= cnt_nxt;
            idx_r      <= idx_nxt;
            rd_r       <= rd_nxt;
            frame_q_r  <= bus.FRAME_;
            devsel_n_r <= devsel_n_nxt;
            trdy_n_r   <= trdy_n_nxt;
            ad_oe_r    <= ad_oe_nxt;
        end
    end

    assign bus.DEVSEL_ = devsel_n_r;
    assign bus.TRDY_   = trdy_n_r;
    assign bus.ad_oe   = ad_oe_r;
    assign bus.ad_out  = ad_oe_r ? rd_word_s : 32'h0000_0000;

endmodule

// File: tb/tb_pci_mem_target.sv
// Directed bench for pci_mem_target: one target with default latency (a)
// and one with DEVSEL_DLY=3, WAIT_STATES=2 (b), driven by a simple master.
module tb_pci_mem_target;
    import pci_pkg::*;

    logic clk;
    logic rst;

    logic       frame_v [2];
    logic       irdy_v  [2];
    logic [3:0] cbe_v   [2];
    word_t      adin_v  [2];

    int n_checks;
    int n_errors;

    word_t wbuf [16];

    pci_mem_target_if bus_a ();
    pci_mem_target_if bus_b ();

    assign bus_a.FRAME_ = frame_v[0];
    assign bus_a.IRDY_  = irdy_v[0];
    assign bus_a.C_BE_  = cbe_v[0];
    assign bus_a.ad_in  = adin_v[0];
    assign bus_b.FRAME_ = frame_v[1];
    assign bus_b.IRDY_  = irdy_v[1];
    assign bus_b.C_BE_  = cbe_v[1];
    assign bus_b.ad_in  = adin_v[1];

    pci_mem_target #(
        .BASE_ADDR   (32'h1000_0000),
        .ADDR_BITS   (4),
        .DEVSEL_DLY  (1),
        .WAIT_STATES (0)
    ) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    pci_mem_target #(
        .BASE_ADDR   (32'h1000_0000),
        .ADDR_BITS   (4),
        .DEVSEL_DLY  (3),
        .WAIT_STATES (2)
    ) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic dev_of(input int sel);
        return (sel == 0) ? bus_a.DEVSEL_ : bus_b.DEVSEL_;
    endfunction

    function automatic logic trdy_of(input int sel);
        return (sel == 0) ? bus_a.TRDY_ : bus_b.TRDY_;
    endfunction

    function automatic logic oe_of(input int sel);
        return (sel == 0) ? bus_a.ad_oe : bus_b.ad_oe;
    endfunction

    function automatic word_t adout_of(input int sel);
        return (sel == 0) ? bus_a.ad_out : bus_b.ad_out;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One claimed transaction of n data phases. For writes wbuf holds the
    // data sent, for reads the data expected. Optional IRDY_ stall before
    // transfer stall_at, optional reset after abort_at transfers.
    task automatic burst(input int sel, input string tag, input logic [3:0] cmd,
                         input word_t addr, input logic [3:0] be, input int n,
                         input int stall_at, input int stall_len, input int abort_at,
                         output int first_dev, output int first_trdy);
        int  e;
        int  x;
        int  st;
        bit  stalling;
        bit  aborted;
        first_dev  = -1;
        first_trdy = -1;
        e = 0;
        x = 0;
        st = 0;
        aborted = 1'b0;
        frame_v[sel] = 1'b1;
        irdy_v[sel]  = 1'b1;
        cyc();
        frame_v[sel] = 1'b0;
        cbe_v[sel]   = cmd;
        adin_v[sel]  = addr;
        cyc();
        while (x < n && e < 40 && !aborted) begin
            stalling     = (x == stall_at) && (st < stall_len) && (trdy_of(sel) == 1'b0);
            irdy_v[sel]  = stalling;
            frame_v[sel] = (x == n - 1) && !stalling;
            cbe_v[sel]   = be;
            adin_v[sel]  = (cmd == CMD_MEM_WRITE) ? wbuf[x] : 32'h0000_0000;
            if (dev_of(sel) == 1'b0 && first_dev < 0) first_dev = e + 1;
            if (trdy_of(sel) == 1'b0 && first_trdy < 0) first_trdy = e + 1;
            if (stalling) begin
                check({tag, "_stall_hold"}, adout_of(sel), wbuf[x]);
                st++;
            end else if (trdy_of(sel) == 1'b0) begin
                if (cmd == CMD_MEM_READ) begin
                    check({tag, "_rd_oe"}, {31'h0, oe_of(sel)}, 32'h1);
                    check($sformatf("%s_rd%0d", tag, x), adout_of(sel), wbuf[x]);
                end
                x++;
            end
            cyc();
            e++;
            if (abort_at >= 0 && x == abort_at) begin
                check({tag, "_pre_rst_devsel"}, {31'h0, dev_of(sel)}, 32'h0);
                #2;
                rst = 1'b1;
                #1;
                check({tag, "_rst_devsel"}, {31'h0, dev_of(sel)}, 32'h1);
                check({tag, "_rst_trdy"},   {31'h0, trdy_of(sel)}, 32'h1);
                check({tag, "_rst_oe"},     {31'h0, oe_of(sel)}, 32'h0);
                frame_v[sel] = 1'b1;
                irdy_v[sel]  = 1'b1;
                cyc();
                cyc();
                rst = 1'b0;
                aborted = 1'b1;
            end
        end
        frame_v[sel] = 1'b1;
        irdy_v[sel]  = 1'b1;
        if (!aborted) begin
            if (x < n) begin
                check({tag, "_timeout"}, x, n);
            end else begin
                check({tag, "_end_devsel"}, {31'h0, dev_of(sel)}, 32'h1);
                check({tag, "_end_trdy"},   {31'h0, trdy_of(sel)}, 32'h1);
                check({tag, "_end_oe"},     {31'h0, oe_of(sel)}, 32'h0);
                check({tag, "_end_adout"},  adout_of(sel), 32'h0);
            end
        end
    endtask

    // Transaction the target must not claim: outputs must stay inactive.
    task automatic no_claim(input int sel, input string tag, input logic [3:0] cmd, input word_t addr);
        int act;
        act = 0;
        frame_v[sel] = 1'b1;
        irdy_v[sel]  = 1'b1;
        cyc();
        frame_v[sel] = 1'b0;
        cbe_v[sel]   = cmd;
        adin_v[sel]  = addr;
        cyc();
        for (int i = 0; i < 6; i++) begin
            frame_v[sel] = (i == 5);
            irdy_v[sel]  = 1'b0;
            cbe_v[sel]   = 4'h0;
            adin_v[sel]  = 32'h5555_5555;
            if (dev_of(sel) == 1'b0 || trdy_of(sel) == 1'b0 || oe_of(sel) == 1'b1) act++;
            cyc();
        end
        if (dev_of(sel) == 1'b0 || trdy_of(sel) == 1'b0 || oe_of(sel) == 1'b1) act++;
        frame_v[sel] = 1'b1;
        irdy_v[sel]  = 1'b1;
        check(tag, act, 0);
    endtask

    task automatic read1(input int sel, input string tag, input word_t addr, input word_t exp);
        int fd;
        int ft;
        wbuf[0] = exp;
        burst(sel, tag, CMD_MEM_READ, addr, 4'h0, 1, -1, 0, -1, fd, ft);
    endtask

    task automatic write1(input int sel, input string tag, input word_t addr, input word_t data, input logic [3:0] be);
        int fd;
        int ft;
        wbuf[0] = data;
        burst(sel, tag, CMD_MEM_WRITE, addr, be, 1, -1, 0, -1, fd, ft);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fd;
        int ft;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            frame_v[s] = 1'b1;
            irdy_v[s]  = 1'b1;
            cbe_v[s]   = 4'h0;
            adin_v[s]  = 32'h0000_0000;
        end
        #12;
        check("reset_devsel_a", {31'h0, bus_a.DEVSEL_}, 32'h1);
        check("reset_trdy_a",   {31'h0, bus_a.TRDY_},   32'h1);
        check("reset_oe_a",     {31'h0, bus_a.ad_oe},   32'h0);
        check("reset_adout_a",  bus_a.ad_out,           32'h0);
        check("reset_devsel_b", {31'h0, bus_b.DEVSEL_}, 32'h1);
        check("reset_trdy_b",   {31'h0, bus_b.TRDY_},   32'h1);
        #10;
        rst = 1'b0;
        cyc();

        // Single write then read, default latency.
        wbuf[0] = 32'hDEAD_BEEF;
        burst(0, "sw", CMD_MEM_WRITE, 32'h1000_0008, 4'h0, 1, -1, 0, -1, fd, ft);
        check("sw_first_devsel", fd, 1);
        check("sw_first_trdy",   ft, 1);
        wbuf[0] = 32'hDEAD_BEEF;
        burst(0, "sr", CMD_MEM_READ, 32'h1000_0008, 4'h0, 1, -1, 0, -1, fd, ft);
        check("sr_first_devsel", fd, 1);
        check("sr_first_trdy",   ft, 2);

        // Burst with index wrap from word 15 to word 0.
        wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3; wbuf[3] = 32'h4;
        burst(0, "bw", CMD_MEM_WRITE, 32'h1000_0038, 4'h0, 4, -1, 0, -1, fd, ft);
        wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3; wbuf[3] = 32'h4;
        burst(0, "br", CMD_MEM_READ, 32'h1000_0038, 4'h0, 4, -1, 0, -1, fd, ft);
        read1(0, "wrap_w0", 32'h1000_0000, 32'h3);
        read1(0, "wrap_w1", 32'h1000_0004, 32'h4);

        // Byte enables: lanes 0 and 2 enabled.
        write1(0, "be_init", 32'h1000_000C, 32'h1122_3344, 4'h0);
        write1(0, "be_part", 32'h1000_000C, 32'hAABB_CCDD, 4'b1010);
        read1(0, "be_rd", 32'h1000_000C, 32'h11BB_33DD);

        // Address miss and unsupported command.
        no_claim(0, "miss_quiet", CMD_MEM_WRITE, 32'h2000_0008);
        read1(0, "miss_mem", 32'h1000_0008, 32'hDEAD_BEEF);
        no_claim(0, "badcmd_quiet", 4'b0010, 32'h1000_0008);
        read1(0, "badcmd_mem", 32'h1000_0008, 32'hDEAD_BEEF);

        // Slow target: latency sweep and master stall mid-burst.
        wbuf[0] = 32'hA0A0_0001; wbuf[1] = 32'hA0A0_0002; wbuf[2] = 32'hA0A0_0003; wbuf[3] = 32'hA0A0_0004;
        burst(1, "lw", CMD_MEM_WRITE, 32'h1000_0014, 4'h0, 4, -1, 0, -1, fd, ft);
        check("lw_first_devsel", fd, 3);
        check("lw_first_trdy",   ft, 5);
        burst(1, "lr", CMD_MEM_READ, 32'h1000_0014, 4'h0, 4, 2, 2, -1, fd, ft);
        check("lr_first_devsel", fd, 3);
        check("lr_first_trdy",   ft, 5);

        // Slow target: master abandons while still waiting for TRDY_.
        frame_v[1] = 1'b1;
        irdy_v[1]  = 1'b1;
        cyc();
        frame_v[1] = 1'b0;
        cbe_v[1]   = CMD_MEM_READ;
        adin_v[1]  = 32'h1000_0014;
        cyc();
        cyc();
        cyc();
        check("ab_devsel_low", {31'h0, bus_b.DEVSEL_}, 32'h0);
        check("ab_oe_high",    {31'h0, bus_b.ad_oe},   32'h1);
        frame_v[1] = 1'b1;
        cyc();
        check("ab_devsel_rel", {31'h0, bus_b.DEVSEL_}, 32'h1);
        check("ab_oe_rel",     {31'h0, bus_b.ad_oe},   32'h0);
        cyc();
        cyc();
        check("ab_trdy_quiet", {31'h0, bus_b.TRDY_},   32'h1);

        // Reset between transfers 2 and 3 of a 4-word write.
        wbuf[0] = 32'hCAFE_0000; wbuf[1] = 32'hCAFE_0001; wbuf[2] = 32'hCAFE_0002; wbuf[3] = 32'hCAFE_0003;
        burst(0, "rst", CMD_MEM_WRITE, 32'h1000_0000, 4'h0, 4, -1, 0, 2, fd, ft);
        read1(0, "rst_w0_clr", 32'h1000_0000, 32'h0);
        read1(1, "rst_b_w5_clr", 32'h1000_0014, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
